sub_bytes_engine: RTL and testbench

Parametrised, multi-cycle AES SubBytes/InvSubBytes engine for a full 128-bit state. It substitutes LANES bytes per cycle, using LANES dual-mode (forward/inverse) S-box instances, so area can be traded against latency. It sits between the round-key/ShiftRows datapath and the cipher round controller, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/sbox_dual.sv | 12 +
 rtl/sub_bytes_engine.sv | 101 ++++++++++
 tb/tb_sub_bytes_engine.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box tables, state/FSM types and beat helper for sub_bytes_engine
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbe_state_t;

  function automatic int beats_for(input int lanes);
    return 16 / lanes;
  endfunction

  localparam logic [7:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_dual.sv
// rtl/sbox_dual.sv - combinational AES S-box with forward/inverse select
module sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  assign out = inv ? SBOX_INV[in] : SBOX_FWD[in];

endmodule

// File: rtl/sub_bytes_engine.sv
// rtl/sub_bytes_engine.sv - multi-cycle AES SubBytes/InvSubBytes over a 128-bit state, LANES bytes per beat
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int BEATS = beats_for(LANES);
  localparam int KW    = $clog2(BEATS) + 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sbe_state_t      state;
  aes_state_t      state_q;
  aes_state_t      sub_state;
  logic [KW-1:0]   k;
  logic            mode_q;
  logic            accept;
  logic [3:0]      lane_idx [LANES];
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // in_ready depends on out_ready only in DONE, never on in_valid
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = state_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(32'(k) * LANES + l);
    assign lane_in[l]  = state_q[8*(15 - int'(lane_idx[l])) +: 8];
    sbox_dual u_sbox (
      .in  (lane_in[l]),
      .inv (mode_q),
      .out (lane_out[l])
    );
  end

  always_comb begin
    sub_state = state_q;
    for (int l = 0; l < LANES; l++) begin
      sub_state[8*(15 - int'(lane_idx[l])) +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      state_q <= '0;
      k       <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_q <= in_data;
            mode_q  <= in_inv;
            k       <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          state_q <= sub_state;
          k       <= k + KW'(1);
          if (k == KW'(BEATS - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // a new block may be taken in the same cycle the result leaves
          if (out_ready) begin
            if (in_valid) begin
              state_q <= in_data;
              mode_q  <= in_inv;
              k       <= '0;
              state   <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb/tb_sub_bytes_engine.sv - directed self-checking bench for sub_bytes_engine (LANES 4, 1, 16)
module tb_sub_bytes_engine;

  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_data   [NDUT];
  logic         in_inv    [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_data  [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    sub_bytes_engine #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  function automatic int beats_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 16 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w = {v, v};
    return w[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      fwd_tab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
  endtask

  function automatic logic [127:0] model_block(input logic [127:0] data, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = inv ? inv_tab[data[127-8*i -: 8]] : fwd_tab[data[127-8*i -: 8]];
    end
    return r;
  endfunction

  task automatic wait_valid(input int d, input bit toggle, output int lat);
    lat = 0;
    while (!out_valid[d] && lat <= 40) begin
      if (toggle) in_inv[d] = ~in_inv[d];
      @(negedge clk);
      lat++;
    end
    if (lat > 40) check_eq("out_valid_timeout", 128'(out_valid[d]), 128'd1);
  endtask

  task automatic run_block(input int d, input logic [127:0] data, input logic inv, input bit toggle,
                           output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_inv[d]   = inv;
    check_eq("in_ready_idle", 128'(in_ready[d]), 128'd1);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_data[d]  = ~data;
    wait_valid(d, toggle, lat);
    res = out_data[d];
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  logic [127:0] res;
  logic [127:0] held;
  logic [127:0] blk;
  int           lat;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_inv[d] = 1'b0; out_ready[d] = 1'b0;
    end
    build_tables();

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready[0]), 128'd0);
    check_eq("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("rst_out_data", out_data[0], 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 128'(in_ready[0]), 128'd1);

    // LANES=4 forward vector
    run_block(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, res, lat);
    check_eq("l4_fwd_data", res, 128'h638293c31bfc33f5c4eeacea4bc12816);
    check_eq("l4_fwd_model", res, model_block(128'h00112233445566778899aabbccddeeff, 1'b0));
    check_eq("l4_fwd_lat", 128'(lat), 128'd4);

    // LANES=1 inverse round trip and single bytes
    run_block(1, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 1'b0, res, lat);
    check_eq("l1_inv_data", res, 128'h00112233445566778899aabbccddeeff);
    check_eq("l1_inv_lat", 128'(lat), 128'd16);
    run_block(1, {8'h53, 8'h00, 112'h0}, 1'b0, 1'b0, res, lat);
    check_eq("l1_byte_53_fwd", 128'(res[127:120]), 128'hed);
    check_eq("l1_byte_00_fwd", 128'(res[119:112]), 128'h63);
    run_block(1, {8'hed, 120'h0}, 1'b1, 1'b0, res, lat);
    check_eq("l1_byte_ed_inv", 128'(res[127:120]), 128'h53);

    // LANES=16 exhaustive, both modes
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(b*16 + i);
      for (int m = 0; m < 2; m++) begin
        run_block(2, blk, m[0], 1'b0, res, lat);
        check_eq(m[0] ? "l16_inv_data" : "l16_fwd_data", res, model_block(blk, m[0]));
        check_eq("l16_lat", 128'(lat), 128'd1);
      end
    end

    // backpressure then back-to-back on LANES=4
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 128'h0123456789abcdeffedcba9876543210; in_inv[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_valid(0, 1'b0, lat);
    held = out_data[0];
    check_eq("bp_a_data", held, model_block(128'h0123456789abcdeffedcba9876543210, 1'b0));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_eq("bp_stable", out_data[0], held);
      check_eq("bp_valid", 128'(out_valid[0]), 128'd1);
      check_eq("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0] = 1'b1; in_data[0] = 128'h637c777bf26b6fc53001672bfed7ab76; in_inv[0] = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check_eq("b2b_in_ready", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0; in_data[0] = '0;
    check_eq("b2b_busy", 128'(out_valid[0]), 128'd0);
    wait_valid(0, 1'b0, lat);
    check_eq("b2b_lat", 128'(lat), 128'(beats_of(0)));
    check_eq("b2b_data", out_data[0], 128'h000102030405060708090a0b0c0d0e0f);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // mode latched at accept despite in_inv toggling
    run_block(0, 128'hdeadbeef00112233cafef00d55aa0f1e, 1'b0, 1'b1, res, lat);
    check_eq("mode_latch_fwd", res, model_block(128'hdeadbeef00112233cafef00d55aa0f1e, 1'b0));
    run_block(0, 128'hdeadbeef00112233cafef00d55aa0f1e, 1'b1, 1'b1, res, lat);
    check_eq("mode_latch_inv", res, model_block(128'hdeadbeef00112233cafef00d55aa0f1e, 1'b1));

    // reset with k==2 on LANES=4
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 128'h00112233445566778899aabbccddeeff; in_inv[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("mid_rst_out_data", out_data[0], 128'd0);
    @(negedge clk);
    check_eq("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    run_block(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, res, lat);
    check_eq("post_rst_data", res, 128'h638293c31bfc33f5c4eeacea4bc12816);
    check_eq("post_rst_lat", 128'(lat), 128'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
